// File: rtl/link_status_ctrl.sv
// link_status_ctrl
// Turns each link-status change reported by the PHY failover stage into a
// sequenced MAC reconfiguration: hold TX, drain, settle, then apply all new
// values in one cycle. Interrupt causes go to a clear-on-read register.
// Build option: define LINK_STATUS_DRAIN_EN to make DRAIN wait for tx_busy
// low, bounded by DRAIN_TIMEOUT. Without it, DRAIN is a single cycle and
// cause bit 3 is never set.
module link_status_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 1250,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_up,
    input  logic [1:0] speed,
    input  logic       full_duplex,
    input  logic       active_port,
    input  logic       link_change,
    input  logic       tx_busy,
    output logic       mac_link,
    output logic [1:0] mac_speed,
    output logic       mac_duplex,
    output logic       mac_port,
    output logic       cfg_update,
    output logic       tx_hold,
    input  logic [3:0] ims,
    input  logic       icr_rd,
    output logic [3:0] icr_rdata,
    output logic       intr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        APPLY  = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        link_d;
    logic [1:0]  speed_d;
    logic        duplex_d;
    logic        port_d;
    logic        cfg_update_d;
    logic [3:0]  icr_q;
    logic [3:0]  icr_set;

`ifdef LINK_STATUS_DRAIN_EN
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT);
`else
    // tx_busy and DRAIN_TIMEOUT only matter when the drain wait is built in.
    logic [16:0] drain_unused;
    assign drain_unused = {tx_busy, 16'(DRAIN_TIMEOUT)};
`endif

    // Next-state, sequence counter, applied values and cause bits.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a variable unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = 16'd0;
        pending_d    = pending_q;
        link_d       = mac_link;
        speed_d      = mac_speed;
        duplex_d     = mac_duplex;
        port_d       = mac_port;
        cfg_update_d = 1'b0;
        icr_set      = 4'b0000;

        case (state_q)
            IDLE: begin
                if (link_change) state_d = DRAIN;
            end

            DRAIN: begin
                if (link_change) pending_d = 1'b1;
`ifdef LINK_STATUS_DRAIN_EN
                if (!tx_busy) begin
                    state_d = SETTLE;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d    = SETTLE;
                    icr_set[3] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                state_d = SETTLE;
`endif
            end

            SETTLE: begin
                if (link_change) pending_d = 1'b1;
                if (cnt_q == HOLD_LAST) state_d = APPLY;
                else                    cnt_d   = cnt_q + 16'd1;
            end

            APPLY: begin
                link_d       = link_up;
                speed_d      = speed;
                duplex_d     = full_duplex;
                port_d       = active_port;
                cfg_update_d = (link_up != mac_link) || (speed != mac_speed) ||
                               (full_duplex != mac_duplex) || (active_port != mac_port);
                icr_set[0]   = (link_up != mac_link);
                icr_set[1]   = link_up && ((speed != mac_speed) || (full_duplex != mac_duplex));
                icr_set[2]   = (active_port != mac_port);
                // A change arriving in this very cycle is folded in directly,
                // since pending is cleared on the way out.
                state_d      = (pending_q || link_change) ? DRAIN : IDLE;
                pending_d    = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    // State, applied configuration, cause register and interrupt outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            pending_q  <= 1'b0;
            mac_link   <= 1'b0;
            mac_speed  <= 2'b10;
            mac_duplex <= 1'b1;
            mac_port   <= 1'b1;
            cfg_update <= 1'b0;
            tx_hold    <= 1'b1;
            icr_q      <= 4'b0000;
            icr_rdata  <= 4'b0000;
            intr       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values from before this edge regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            mac_link   <= link_d;
            mac_speed  <= speed_d;
            mac_duplex <= duplex_d;
            mac_port   <= port_d;
            cfg_update <= cfg_update_d;
            tx_hold    <= (state_d != IDLE) || !link_d;
            // A cause set in the read cycle survives the clear.
            icr_q      <= (icr_rd ? 4'b0000 : icr_q) | icr_set;
            if (icr_rd) icr_rdata <= icr_q;
            intr       <= |(icr_q & ims);
        end
    end

endmodule

// File: tb/tb_link_status_ctrl.sv
// Self-checking bench for link_status_ctrl. Expected timing and values come
// from a reference model of the applied configuration and the cause register,
// computed from the sequencing rules with plain cycle arithmetic.
`timescale 1ns/1ps
module tb_link_status_ctrl;

    localparam int HOLD = 8;
    localparam int DTO  = 24;
`ifdef LINK_STATUS_DRAIN_EN
    localparam bit DRAIN_EN = 1'b1;
`else
    localparam bit DRAIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       link_up;
    logic [1:0] speed;
    logic       full_duplex;
    logic       active_port;
    logic       link_change;
    logic       tx_busy;
    logic       mac_link;
    logic [1:0] mac_speed;
    logic       mac_duplex;
    logic       mac_port;
    logic       cfg_update;
    logic       tx_hold;
    logic [3:0] ims;
    logic       icr_rd;
    logic [3:0] icr_rdata;
    logic       intr;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: configuration the MAC should currently hold, and the
    // cause bits the host has not yet read.
    logic       m_link;
    logic [1:0] m_speed;
    logic       m_duplex;
    logic       m_port;
    logic [3:0] m_icr;

    always #5 clk = ~clk;

    link_status_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link_up    (link_up),
        .speed      (speed),
        .full_duplex(full_duplex),
        .active_port(active_port),
        .link_change(link_change),
        .tx_busy    (tx_busy),
        .mac_link   (mac_link),
        .mac_speed  (mac_speed),
        .mac_duplex (mac_duplex),
        .mac_port   (mac_port),
        .cfg_update (cfg_update),
        .tx_hold    (tx_hold),
        .ims        (ims),
        .icr_rd     (icr_rd),
        .icr_rdata  (icr_rdata),
        .intr       (intr)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_link   = 1'b0;
        m_speed  = 2'b10;
        m_duplex = 1'b1;
        m_port   = 1'b1;
        m_icr    = 4'b0000;
    endtask

    function automatic logic [3:0] exp_causes(input logic nl, input logic [1:0] ns,
                                              input logic nd, input logic np, input bit tmo);
        logic [3:0] c;
        c[0] = (nl != m_link);
        c[1] = nl && ((ns != m_speed) || (nd != m_duplex));
        c[2] = (np != m_port);
        c[3] = tmo;
        return c;
    endfunction

    task automatic check_reset_values(input string name);
        checks++; if (mac_link !== 1'b0) begin errors++; $display("FAIL %s_mac_link: got %b expected 0", name, mac_link); end
        checks++; if (mac_speed !== 2'b10) begin errors++; $display("FAIL %s_mac_speed: got %b expected 10", name, mac_speed); end
        checks++; if (mac_duplex !== 1'b1) begin errors++; $display("FAIL %s_mac_duplex: got %b expected 1", name, mac_duplex); end
        checks++; if (mac_port !== 1'b1) begin errors++; $display("FAIL %s_mac_port: got %b expected 1", name, mac_port); end
        checks++; if (tx_hold !== 1'b1) begin errors++; $display("FAIL %s_tx_hold: got %b expected 1", name, tx_hold); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL %s_intr: got %b expected 0", name, intr); end
        checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL %s_cfg_update: got %b expected 0", name, cfg_update); end
        checks++; if (icr_rdata !== 4'b0000) begin errors++; $display("FAIL %s_icr_rdata: got %b expected 0000", name, icr_rdata); end
    endtask

    // One complete change sequence. busy_n = cycles tx_busy stays high after
    // the change pulse (large = stuck). rd_at_apply reads the cause register
    // in the APPLY cycle; read_after reads it once the sequence is done.
    task automatic run_change(input logic nl, input logic [1:0] ns, input logic nd,
                              input logic np, input int busy_n, input bit rd_at_apply,
                              input bit read_after, input string name);
        int         t, a, dlen;
        bit         tmo;
        logic [3:0] cz, old_icr;
        logic       diff;
        link_up     = nl;
        speed       = ns;
        full_duplex = nd;
        active_port = np;
        tx_busy     = 1'b0;
        if (DRAIN_EN) begin
            tmo  = (busy_n > DTO);
            dlen = (tmo ? DTO : busy_n) + 1;
        end else begin
            tmo  = 1'b0;
            dlen = 1;
        end
        t       = cyc;
        a       = t + 1 + dlen + HOLD;
        cz      = exp_causes(nl, ns, nd, np, tmo);
        diff    = ({nl, ns, nd, np} != {m_link, m_speed, m_duplex, m_port});
        old_icr = m_icr;
        link_change = 1'b1;
        while (cyc < a + 1) begin
            if (cyc == a && rd_at_apply) icr_rd = 1'b1;
            tick();
            icr_rd      = 1'b0;
            link_change = 1'b0;
            tx_busy     = ((cyc - t) <= busy_n);
            if (cyc <= a) begin
                checks++; if (tx_hold !== 1'b1) begin errors++; $display("FAIL %s_hold_cyc%0d: got %b expected 1", name, cyc - t, tx_hold); end
                checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL %s_early_cfg_cyc%0d: got %b expected 0", name, cyc - t, cfg_update); end
            end
        end
        tx_busy = 1'b0;
        checks++; if (cfg_update !== diff) begin errors++; $display("FAIL %s_cfg_update: got %b expected %b", name, cfg_update, diff); end
        checks++; if ({mac_link, mac_speed, mac_duplex, mac_port} !== {nl, ns, nd, np})
            begin errors++; $display("FAIL %s_applied: got %b expected %b", name, {mac_link, mac_speed, mac_duplex, mac_port}, {nl, ns, nd, np}); end
        checks++; if (tx_hold !== !nl) begin errors++; $display("FAIL %s_hold_after: got %b expected %b", name, tx_hold, !nl); end
        m_link = nl; m_speed = ns; m_duplex = nd; m_port = np;
        if (rd_at_apply) begin
            checks++; if (icr_rdata !== old_icr) begin errors++; $display("FAIL %s_rd_at_apply: got %b expected %b", name, icr_rdata, old_icr); end
            m_icr = cz;
        end else begin
            m_icr = m_icr | cz;
        end
        tick();
        checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL %s_cfg_pulse_width: got %b expected 0", name, cfg_update); end
        checks++; if (intr !== |(m_icr & ims)) begin errors++; $display("FAIL %s_intr: got %b expected %b", name, intr, |(m_icr & ims)); end
        if (read_after) begin
            icr_rd = 1'b1;
            tick();
            icr_rd = 1'b0;
            checks++; if (icr_rdata !== m_icr) begin errors++; $display("FAIL %s_icr: got %b expected %b", name, icr_rdata, m_icr); end
            m_icr = 4'b0000;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; link_up = 1'b0; speed = 2'b00; full_duplex = 1'b0; active_port = 1'b0;
        link_change = 1'b0; tx_busy = 1'b0; ims = 4'b0000; icr_rd = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        check_reset_values("reset");
    endtask

    task automatic test_link_up();
        ims = 4'hF;
        run_change(1'b1, 2'b10, 1'b1, 1'b1, 0, 1'b0, 1'b1, "link_up");
    endtask

    task automatic test_no_change();
        run_change(m_link, m_speed, m_duplex, m_port, 0, 1'b0, 1'b1, "no_change");
    endtask

    task automatic test_drain();
        run_change(1'b1, 2'b01, 1'b0, 1'b1, 20, 1'b0, 1'b1, "drain20");
        run_change(1'b1, 2'b01, 1'b0, 1'b1, 1000, 1'b0, 1'b1, "drain_stuck");
    endtask

    task automatic test_clear_on_read();
        run_change(1'b0, m_speed, m_duplex, m_port, 0, 1'b0, 1'b0, "cor_down");
        run_change(1'b1, m_speed, m_duplex, m_port, 0, 1'b1, 1'b1, "cor_up");
    endtask

    task automatic test_back_to_back();
        int         t, a1, a2;
        logic [3:0] cz;
        logic       diff;
        ims = 4'hF;
        link_up = m_link; speed = m_speed; full_duplex = m_duplex; active_port = m_port;
        tx_busy = 1'b0;
        t = cyc;
        link_change = 1'b1;
        tick();
        link_change = 1'b0;
        repeat (3) tick();
        active_port = ~m_port;
        link_change = 1'b1;
        tick();
        link_change = 1'b0;
        a1   = t + 2 + HOLD;
        cz   = exp_causes(link_up, speed, full_duplex, active_port, 1'b0);
        diff = (active_port != m_port);
        while (cyc < a1 + 1) tick();
        checks++; if (cfg_update !== diff) begin errors++; $display("FAIL b2b_first_cfg: got %b expected %b", cfg_update, diff); end
        checks++; if (mac_port !== active_port) begin errors++; $display("FAIL b2b_first_port: got %b expected %b", mac_port, active_port); end
        checks++; if (tx_hold !== 1'b1) begin errors++; $display("FAIL b2b_hold_between: got %b expected 1", tx_hold); end
        m_port = active_port;
        m_icr  = m_icr | cz;
        a2 = a1 + 2 + HOLD;
        while (cyc < a2 + 1) begin
            tick();
            if (cyc <= a2) begin
                checks++; if (tx_hold !== 1'b1) begin errors++; $display("FAIL b2b_second_hold: got %b expected 1", tx_hold); end
            end
        end
        checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL b2b_second_cfg: got %b expected 0", cfg_update); end
        checks++; if (mac_port !== m_port) begin errors++; $display("FAIL b2b_final_port: got %b expected %b", mac_port, m_port); end
        checks++; if (tx_hold !== !m_link) begin errors++; $display("FAIL b2b_final_hold: got %b expected %b", tx_hold, !m_link); end
        icr_rd = 1'b1;
        tick();
        icr_rd = 1'b0;
        checks++; if (icr_rdata !== m_icr) begin errors++; $display("FAIL b2b_icr: got %b expected %b", icr_rdata, m_icr); end
        m_icr = 4'b0000;
    endtask

    task automatic test_mid_reset();
        ims = 4'hF;
        link_up = ~m_link; active_port = ~m_port;
        link_change = 1'b1;
        tick();
        link_change = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_reset_values("mid_reset");
        rst_n = 1'b1;
        model_reset();
        repeat (HOLD + 6) begin
            tick();
            checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL mid_reset_late_cfg: got %b expected 0", cfg_update); end
            checks++; if (mac_link !== 1'b0) begin errors++; $display("FAIL mid_reset_late_link: got %b expected 0", mac_link); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            ims = 4'($urandom);
            run_change(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)), "random");
        end
        icr_rd = 1'b1;
        tick();
        icr_rd = 1'b0;
        checks++; if (icr_rdata !== m_icr) begin errors++; $display("FAIL random_final_icr: got %b expected %b", icr_rdata, m_icr); end
        m_icr = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_no_change();
        test_drain();
        test_clear_on_read();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
